// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: exception codes,
// function selects, the buffered result entry and commit FSM states.
package alu_pkg;

    localparam logic [3:0] EXC_NONE    = 4'b0000;
    localparam logic [3:0] EXC_OVF     = 4'b0001;
    localparam logic [3:0] EXC_UNKNOWN = 4'b1000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Tag width carried in a buffered entry; the commit block's
    // TAG_W parameter is expected to match it.
    localparam int RES_TAG_W = 5;

    typedef struct packed {
        logic [31:0]          data;
        logic                 carry;
        logic [3:0]           exc;
        logic [RES_TAG_W-1:0] tag;
    } resEntry_t;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } commitState_t;

    function automatic logic isFault(input logic [3:0] exc);
        return exc != EXC_NONE;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// In-order result queue: push at tail, pop at head, flush clears all.
// Ports: clk, reset, push/pushEntry, pop, flush, head, count.
module result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  resEntry_t              pushEntry,
    input  logic                   pop,
    input  logic                   flush,
    output resEntry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    resEntry_t     mem [DEPTH];
    logic [AW-1:0] headPtr;
    logic [AW-1:0] tailPtr;
    logic          doPush;
    logic          doPop;

    // A full queue refuses pushes even if the head leaves this cycle.
    assign doPush = push && (count != CW'(DEPTH));
    assign doPop  = pop && (count != '0);

    // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPush) tailPtr <= tailPtr + 1'b1;
            if (doPop)  headPtr <= headPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (doPush) mem[tailPtr] <= pushEntry;
    end

    assign head = mem[headPtr];

endmodule

// File: rtl/alu_result_commit.sv
// Buffers ALU results and commits them in order to the register file,
// raising a held exception report (with queue flush) on a faulting head.
// Ports: ALU side validIn/dataIn/carryIn/excIn/tagIn/allowOut;
// regfile side wrEn/wrAddr/wrData/wrReady; flagCarry; excValid/excCode/
// excTag/excAck exception report.
module alu_result_commit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = RES_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn,
    input  logic [31:0]      dataIn,
    input  logic             carryIn,
    input  logic [3:0]       excIn,
    input  logic [TAG_W-1:0] tagIn,
    output logic             allowOut,
    output logic             wrEn,
    output logic [TAG_W-1:0] wrAddr,
    output logic [31:0]      wrData,
    input  logic             wrReady,
    output logic             flagCarry,
    output logic             excValid,
    output logic [3:0]       excCode,
    output logic [TAG_W-1:0] excTag,
    input  logic             excAck
);

    localparam int CW = $clog2(DEPTH) + 1;

    commitState_t  state;
    resEntry_t     inEntry;
    resEntry_t     head;
    logic [CW-1:0] count;
    logic          headValid;
    logic          fault;
    logic          push;
    logic          pop;

    assign inEntry.data  = dataIn;
    assign inEntry.carry = carryIn;
    assign inEntry.exc   = excIn;
    assign inEntry.tag   = RES_TAG_W'(tagIn);

    // allowOut depends on registered state only.
    assign allowOut  = (count < CW'(DEPTH)) && (state == RUN);
    assign push      = validIn && allowOut;
    assign headValid = (count != '0);

    assign fault  = (state == RUN) && headValid && isFault(head.exc);
    assign wrEn   = (state == RUN) && headValid && !isFault(head.exc);
    assign wrAddr = TAG_W'(head.tag);
    assign wrData = head.data;
    assign pop    = wrEn && wrReady;

    result_fifo #(
        .DEPTH(DEPTH)
    ) fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushEntry(inEntry),
        .pop      (pop),
        .flush    (fault),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            excValid  <= 1'b0;
            excCode   <= EXC_NONE;
            excTag    <= '0;
            flagCarry <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (fault) begin
                        state    <= EXC;
                        excValid <= 1'b1;
                        excCode  <= head.exc;
                        excTag   <= TAG_W'(head.tag);
                    end else if (pop) begin
                        flagCarry <= head.carry;
                    end
                end
                EXC: begin
                    if (excAck) begin
                        state    <= RUN;
                        excValid <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
